// File: rtl/core_memory.sv
// Memory stage: one load/store in flight over a req/gnt + rvalid data bus, results to writeback.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing them aligned.
module core_memory #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned BUS_HOLD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    // upstream (execute results)
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [31:0]       m_pc,
    input  logic [31:0]       m_imm,
    input  logic [31:0]       m_rs2,
    input  logic [31:0]       m_alu_out,
    input  logic [31:0]       m_alu_sum,
    input  logic [4:0]        m_rd,
    input  logic              m_reg_wen,
    input  logic [1:0]        m_reg_wsel,
    input  logic [2:0]        m_mem_type,
    input  logic              m_mem_ren,
    input  logic              m_mem_wen,
    input  logic [31:0]       m_csr_value,
    // data bus
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    // downstream (writeback)
    output logic              w_valid,
    input  logic              w_ready,
    output logic [4:0]        w_rd,
    output logic              w_reg_wen,
    output logic [31:0]       w_wdata
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              w_exc,
    output logic [3:0]        w_exc_cause,
    output logic [31:0]       w_badaddr
`endif
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e             state_q, state_d;
    logic               w_valid_q, w_valid_d, w_reg_wen_q, w_reg_wen_d;
    logic [4:0]         w_rd_q, w_rd_d, pend_rd_q, pend_rd_d;
    logic [31:0]        w_wdata_q, w_wdata_d, wdata_q, wdata_d;
    logic               pend_wen_q, pend_wen_d;
    logic               req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [2:0]         ld_type_q, ld_type_d;
    logic [1:0]         ld_off_q, ld_off_d;
`ifdef MISALIGN_TRAP_EN
    logic               exc_q, exc_d;
    logic [3:0]         cause_q, cause_d;
    logic [31:0]        badaddr_q, badaddr_d;
    logic               misaligned;
`endif

    logic        accept, mem_op;
    logic [1:0]  a_lo, eff_off;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, sel_wdata, lane, load_val;
    logic        unused_inputs;

    assign unused_inputs = ^{m_imm, m_alu_sum};

    assign m_ready = rst_n & (state_q == StIdle) & (~w_valid_q | w_ready);
    assign accept  = m_valid & m_ready;
    assign mem_op  = m_mem_ren | m_mem_wen;
    assign a_lo    = m_alu_sum[1:0];

    // Offending low address bits of misaligned H/W accesses are dropped.
    always_comb begin
        eff_off  = 2'b00;
        st_be    = 4'b1111;
        st_wdata = m_rs2;
        unique case (m_mem_type[1:0])
            2'b00: begin
                eff_off  = a_lo;
                st_be    = 4'b0001 << a_lo;
                st_wdata = {4{m_rs2[7:0]}};
            end
            2'b01: begin
                eff_off  = {a_lo[1], 1'b0};
                st_be    = 4'b0011 << {a_lo[1], 1'b0};
                st_wdata = {2{m_rs2[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((m_mem_type[1:0] == 2'b01) & a_lo[0]) |
                        ((m_mem_type[1:0] == 2'b10) & (a_lo != 2'b00));
`endif

    always_comb begin
        sel_wdata = m_alu_out;
        unique case (m_reg_wsel)
            2'd2:    sel_wdata = m_pc + 32'd4;
            2'd3:    sel_wdata = m_csr_value;
            default: sel_wdata = m_alu_out;
        endcase
    end

    always_comb begin
        lane     = dmem_rdata >> {ld_off_q, 3'b000};
        load_val = lane;
        unique case (ld_type_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'd0, lane[7:0]};
            3'b101:  load_val = {16'd0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        w_valid_d   = w_valid_q & ~w_ready;
        w_rd_d      = w_rd_q;
        w_reg_wen_d = w_reg_wen_q;
        w_wdata_d   = w_wdata_q;
        pend_rd_d   = pend_rd_q;
        pend_wen_d  = pend_wen_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        ld_type_d   = ld_type_q;
        ld_off_d    = ld_off_q;
`ifdef MISALIGN_TRAP_EN
        exc_d       = exc_q;
        cause_d     = cause_q;
        badaddr_d   = badaddr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept && !mem_op) begin
                    w_valid_d   = 1'b1;
                    w_rd_d      = m_rd;
                    w_reg_wen_d = m_reg_wen;
                    w_wdata_d   = sel_wdata;
`ifdef MISALIGN_TRAP_EN
                    exc_d       = 1'b0;
                end else if (accept && misaligned) begin
                    w_valid_d   = 1'b1;
                    w_rd_d      = m_rd;
                    w_reg_wen_d = 1'b0;
                    w_wdata_d   = 32'd0;
                    exc_d       = 1'b1;
                    cause_d     = m_mem_ren ? 4'd4 : 4'd6;
                    badaddr_d   = m_alu_sum;
`endif
                end else if (accept) begin
                    state_d    = StReq;
                    req_d      = 1'b1;
                    we_d       = m_mem_wen;
                    addr_d     = {m_alu_sum[ADDR_W-1:2], 2'b00};
                    be_d       = m_mem_wen ? st_be : 4'b1111;
                    wdata_d    = m_mem_wen ? st_wdata : 32'd0;
                    pend_rd_d  = m_rd;
                    pend_wen_d = m_reg_wen;
                    ld_type_d  = m_mem_type;
                    ld_off_d   = eff_off;
                end
            end
            StReq: begin
                if (dmem_gnt) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d     = StIdle;
                        w_valid_d   = 1'b1;
                        w_rd_d      = pend_rd_q;
                        w_reg_wen_d = 1'b0;
                        w_wdata_d   = 32'd0;
`ifdef MISALIGN_TRAP_EN
                        exc_d       = 1'b0;
`endif
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (dmem_rvalid) begin
                    state_d     = StIdle;
                    w_valid_d   = 1'b1;
                    w_rd_d      = pend_rd_q;
                    w_reg_wen_d = pend_wen_q;
                    w_wdata_d   = load_val;
`ifdef MISALIGN_TRAP_EN
                    exc_d       = 1'b0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            w_valid_q   <= 1'b0;
            w_rd_q      <= 5'd0;
            w_reg_wen_q <= 1'b0;
            w_wdata_q   <= 32'd0;
            pend_rd_q   <= 5'd0;
            pend_wen_q  <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= 4'd0;
            wdata_q     <= 32'd0;
            ld_type_q   <= 3'd0;
            ld_off_q    <= 2'd0;
`ifdef MISALIGN_TRAP_EN
            exc_q       <= 1'b0;
            cause_q     <= 4'd0;
            badaddr_q   <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            w_valid_q   <= w_valid_d;
            w_rd_q      <= w_rd_d;
            w_reg_wen_q <= w_reg_wen_d;
            w_wdata_q   <= w_wdata_d;
            pend_rd_q   <= pend_rd_d;
            pend_wen_q  <= pend_wen_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            ld_type_q   <= ld_type_d;
            ld_off_q    <= ld_off_d;
`ifdef MISALIGN_TRAP_EN
            exc_q       <= exc_d;
            cause_q     <= cause_d;
            badaddr_q   <= badaddr_d;
`endif
        end
    end

    // With BUS_HOLD=0 the bus fields read as zero whenever no request is pending.
    assign dmem_req   = req_q;
    assign dmem_we    = (BUS_HOLD != 0 || req_q) ? we_q : 1'b0;
    assign dmem_addr  = (BUS_HOLD != 0 || req_q) ? addr_q : '0;
    assign dmem_be    = (BUS_HOLD != 0 || req_q) ? be_q : 4'd0;
    assign dmem_wdata = (BUS_HOLD != 0 || req_q) ? wdata_q : 32'd0;

    assign w_valid   = w_valid_q;
    assign w_rd      = w_rd_q;
    assign w_reg_wen = w_reg_wen_q;
    assign w_wdata   = w_wdata_q;
`ifdef MISALIGN_TRAP_EN
    assign w_exc       = exc_q;
    assign w_exc_cause = cause_q;
    assign w_badaddr   = badaddr_q;
`endif

endmodule

// File: tb/tb_core_memory.sv
// Self-checking bench for core_memory: randomized ALU/load/store traffic against a
// transaction-level reference model; honours MISALIGN_TRAP_EN when defined.
module tb_core_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_valid, m_ready;
    logic [31:0] m_pc, m_imm, m_rs2, m_alu_out, m_alu_sum, m_csr_value;
    logic [4:0]  m_rd;
    logic        m_reg_wen;
    logic [1:0]  m_reg_wsel;
    logic [2:0]  m_mem_type;
    logic        m_mem_ren, m_mem_wen;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        w_valid, w_ready, w_reg_wen;
    logic [4:0]  w_rd;
    logic [31:0] w_wdata;
`ifdef MISALIGN_TRAP_EN
    logic        w_exc;
    logic [3:0]  w_exc_cause;
    logic [31:0] w_badaddr;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    core_memory dut (
        .clk(clk), .rst_n(rst_n),
        .m_valid(m_valid), .m_ready(m_ready), .m_pc(m_pc), .m_imm(m_imm), .m_rs2(m_rs2),
        .m_alu_out(m_alu_out), .m_alu_sum(m_alu_sum), .m_rd(m_rd), .m_reg_wen(m_reg_wen),
        .m_reg_wsel(m_reg_wsel), .m_mem_type(m_mem_type), .m_mem_ren(m_mem_ren),
        .m_mem_wen(m_mem_wen), .m_csr_value(m_csr_value),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata),
        .w_valid(w_valid), .w_ready(w_ready), .w_rd(w_rd), .w_reg_wen(w_reg_wen),
        .w_wdata(w_wdata)
`ifdef MISALIGN_TRAP_EN
        , .w_exc(w_exc), .w_exc_cause(w_exc_cause), .w_badaddr(w_badaddr)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Byte offset actually used: H drops bit 0, W drops both bits.
    function automatic int ref_off(input logic [2:0] t, input logic [31:0] a);
        if (t[1:0] == 2'b00) ref_off = int'(a % 4);
        else if (t[1:0] == 2'b01) ref_off = int'((a % 4) / 2) * 2;
        else ref_off = 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] a,
                                             input logic [31:0] word);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = word >> (8 * ref_off(t, a));
        b = sh[7:0];
        h = sh[15:0];
        case (t)
            3'b000:  ref_load = 32'($signed(b));
            3'b001:  ref_load = 32'($signed(h));
            3'b100:  ref_load = 32'(b);
            3'b101:  ref_load = 32'(h);
            default: ref_load = word;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] t, input logic [31:0] a);
        if (t[1:0] == 2'b00) ref_be = 4'(1 << ref_off(t, a));
        else if (t[1:0] == 2'b01) ref_be = (ref_off(t, a) == 2) ? 4'b1100 : 4'b0011;
        else ref_be = 4'b1111;
    endfunction

    function automatic logic [31:0] ref_sdata(input logic [2:0] t, input logic [31:0] d);
        if (t[1:0] == 2'b00) ref_sdata = (d & 32'hFF) * 32'h0101_0101;
        else if (t[1:0] == 2'b01) ref_sdata = (d & 32'hFFFF) * 32'h0001_0001;
        else ref_sdata = d;
    endfunction

    task automatic idle_inputs();
        m_valid = 0; m_pc = 0; m_imm = 0; m_rs2 = 0; m_alu_out = 0; m_alu_sum = 0;
        m_csr_value = 0; m_rd = 0; m_reg_wen = 0; m_reg_wsel = 0; m_mem_type = 0;
        m_mem_ren = 0; m_mem_wen = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    // Full memory transaction: gd idle REQ cycles before gnt, rvalid rv cycles after gnt.
    task automatic do_mem(input bit st, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] rs2, input logic [31:0] rdata,
                          input int gd, input int rv, input logic [4:0] rd);
        logic [31:0] exp_addr, exp_wd, exp_ld;
        logic [3:0]  exp_be;
        exp_addr = a & 32'hFFFF_FFFC;
        exp_be   = st ? ref_be(t, a) : 4'b1111;
        exp_wd   = ref_sdata(t, rs2);
        exp_ld   = ref_load(t, a, rdata);
        m_valid = 1; m_mem_ren = !st; m_mem_wen = st; m_mem_type = t; m_alu_sum = a;
        m_rs2 = rs2; m_rd = rd; m_reg_wen = !st; m_reg_wsel = st ? 2'd0 : 2'd1;
        m_alu_out = $urandom;
        n_vec++;
        if (m_ready !== 1'b1) begin
            n_err++; $display("FAIL mem_accept: m_ready=%b want 1", m_ready);
        end
        step();
        m_valid = 0; m_alu_sum = $urandom; m_rs2 = $urandom; m_rd = 5'($urandom);
        for (int i = 0; i <= gd; i++) begin
            n_vec++;
            if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || dmem_be !== exp_be ||
                dmem_we !== st || (st && dmem_wdata !== exp_wd) || m_ready !== 1'b0) begin
                n_err++;
                $display("FAIL mem_req: req=%b addr=%h be=%b we=%b wd=%h rdy=%b want 1 %h %b %b %h 0",
                         dmem_req, dmem_addr, dmem_be, dmem_we, dmem_wdata, m_ready,
                         exp_addr, exp_be, st, exp_wd);
            end
            if (i == gd) dmem_gnt = 1;
            step();
        end
        dmem_gnt = 0;
        if (st) begin
            n_vec++;
            if (w_valid !== 1'b1 || w_reg_wen !== 1'b0 || w_rd !== rd || dmem_req !== 1'b0) begin
                n_err++;
                $display("FAIL store_done: wv=%b wen=%b rd=%0d req=%b want 1 0 %0d 0",
                         w_valid, w_reg_wen, w_rd, dmem_req, rd);
            end
        end else begin
            for (int i = 0; i < rv - 1; i++) begin
                n_vec++;
                if (dmem_req !== 1'b0 || w_valid !== 1'b0 || m_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL load_wait: req=%b wv=%b rdy=%b want 0 0 0",
                             dmem_req, w_valid, m_ready);
                end
                step();
            end
            dmem_rvalid = 1; dmem_rdata = rdata;
            step();
            dmem_rvalid = 0; dmem_rdata = $urandom;
            n_vec++;
            if (w_valid !== 1'b1 || w_rd !== rd || w_reg_wen !== 1'b1 || w_wdata !== exp_ld) begin
                n_err++;
                $display("FAIL load_done: wv=%b rd=%0d wen=%b wd=%h want 1 %0d 1 %h",
                         w_valid, w_rd, w_reg_wen, w_wdata, rd, exp_ld);
            end
        end
`ifdef MISALIGN_TRAP_EN
        n_vec++;
        if (w_exc !== 1'b0) begin
            n_err++; $display("FAIL no_exc: exc=%b want 0", w_exc);
        end
`endif
    endtask

    task automatic test_reset();
        idle_inputs();
        w_ready = 1; rst_n = 0; m_valid = 1;
        #3;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (m_ready !== 1'b0 || w_valid !== 1'b0 || w_rd !== 5'd0 || w_reg_wen !== 1'b0 ||
                w_wdata !== 32'd0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 ||
                dmem_addr !== 32'd0 || dmem_be !== 4'd0 || dmem_wdata !== 32'd0) begin
                n_err++;
                $display("FAIL reset_state: rdy=%b wv=%b rd=%0d wen=%b wd=%h req=%b we=%b addr=%h be=%b sd=%h want all 0",
                         m_ready, w_valid, w_rd, w_reg_wen, w_wdata, dmem_req, dmem_we,
                         dmem_addr, dmem_be, dmem_wdata);
            end
            step();
        end
        m_valid = 0;
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic test_alu_back_to_back();
        logic [4:0]  e_rd;
        logic        e_wen;
        logic [31:0] e_wd;
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) begin
                m_valid = 1; m_mem_ren = 0; m_mem_wen = 0;
                m_pc = $urandom; m_alu_out = $urandom; m_csr_value = $urandom;
                m_rd = 5'($urandom); m_reg_wen = 1'($urandom);
                case ($urandom_range(0, 2))
                    0: m_reg_wsel = 2'd0;
                    1: m_reg_wsel = 2'd2;
                    default: m_reg_wsel = 2'd3;
                endcase
                if (i == 0) begin
                    m_rd = 5'd5; m_alu_out = 32'h1234; m_reg_wsel = 2'd0; m_reg_wen = 1;
                end
                if (i == 1) m_pc = 32'hFFFF_FFFE;
                e_rd  = m_rd;
                e_wen = m_reg_wen;
                e_wd  = (m_reg_wsel == 2'd2) ? m_pc + 32'd4 :
                        (m_reg_wsel == 2'd3) ? m_csr_value : m_alu_out;
                n_vec++;
                if (m_ready !== 1'b1) begin
                    n_err++; $display("FAIL alu_ready[%0d]: m_ready=%b want 1", i, m_ready);
                end
            end else begin
                m_valid = 0;
            end
            step();
            n_vec++;
            if (i < 20) begin
                if (w_valid !== 1'b1 || w_rd !== e_rd || w_reg_wen !== e_wen || w_wdata !== e_wd) begin
                    n_err++;
                    $display("FAIL alu_result[%0d]: wv=%b rd=%0d wen=%b wd=%h want 1 %0d %b %h",
                             i, w_valid, w_rd, w_reg_wen, w_wdata, e_rd, e_wen, e_wd);
                end
            end else if (w_valid !== 1'b0) begin
                n_err++; $display("FAIL alu_drain: w_valid=%b want 0", w_valid);
            end
        end
    endtask

    task automatic test_stall();
        m_valid = 1; m_mem_ren = 0; m_mem_wen = 0; m_reg_wsel = 0; m_reg_wen = 1;
        m_rd = 5'd9; m_alu_out = 32'hCAFE_0001;
        w_ready = 0;
        step();
        m_rd = 5'd10; m_alu_out = 32'hCAFE_0002;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (m_ready !== 1'b0 || w_valid !== 1'b1 || w_rd !== 5'd9 || w_wdata !== 32'hCAFE_0001) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: rdy=%b wv=%b rd=%0d wd=%h want 0 1 9 cafe0001",
                         i, m_ready, w_valid, w_rd, w_wdata);
            end
            step();
        end
        w_ready = 1;
        #1;
        n_vec++;
        if (m_ready !== 1'b1) begin
            n_err++; $display("FAIL stall_release: m_ready=%b want 1", m_ready);
        end
        step();
        m_valid = 0;
        n_vec++;
        if (w_valid !== 1'b1 || w_rd !== 5'd10 || w_wdata !== 32'hCAFE_0002) begin
            n_err++;
            $display("FAIL stall_next: wv=%b rd=%0d wd=%h want 1 10 cafe0002", w_valid, w_rd, w_wdata);
        end
        step();
    endtask

    task automatic test_spec_mem();
        do_mem(0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF00, 0, 1, 5'd3);
        n_vec++;
        if (w_wdata !== 32'hFFFF_FF80) begin
            n_err++; $display("FAIL lb_example: wd=%h want ffffff80", w_wdata);
        end
        do_mem(0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF00, 0, 1, 5'd4);
        n_vec++;
        if (w_wdata !== 32'h0000_0080) begin
            n_err++; $display("FAIL lbu_example: wd=%h want 00000080", w_wdata);
        end
        do_mem(1, 3'b001, 32'h102, 32'hABCD_1234, 32'h0, 0, 1, 5'd0);
        do_mem(0, 3'b010, 32'h200, 32'h0, 32'h1357_9BDF, 3, 2, 5'd7);
    endtask

    task automatic test_random_mem();
        logic [2:0]  t;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: t = 3'b000;
                1: t = 3'b001;
                2: t = 3'b010;
                3: t = 3'b100;
                default: t = 3'b101;
            endcase
            a = $urandom;
            if (t[1:0] == 2'b01) a = a & ~32'd1;
            if (t[1:0] == 2'b10) a = a & ~32'd3;
            if ($urandom_range(0, 1) == 1 && t[2] == 1'b0)
                do_mem(1, t, a, $urandom, 32'h0, $urandom_range(0, 3), 1, 5'($urandom));
            else
                do_mem(0, t, a, 32'h0, $urandom, $urandom_range(0, 3), $urandom_range(1, 3),
                       5'($urandom));
        end
    endtask

    task automatic test_reset_in_wait();
        m_valid = 1; m_mem_ren = 1; m_mem_wen = 0; m_mem_type = 3'b010;
        m_alu_sum = 32'h40; m_rd = 5'd12; m_reg_wen = 1;
        step();
        m_valid = 0; m_mem_ren = 0;
        dmem_gnt = 1;
        step();
        dmem_gnt = 0;
        rst_n = 0;
        #2;
        n_vec++;
        if (w_valid !== 1'b0 || dmem_req !== 1'b0 || m_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_wait: wv=%b req=%b rdy=%b want 0 0 0", w_valid, dmem_req, m_ready);
        end
        @(negedge clk);
        rst_n = 1;
        dmem_rvalid = 1; dmem_gnt = 1; dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_rvalid = 0; dmem_gnt = 0;
        n_vec++;
        if (w_valid !== 1'b0 || dmem_req !== 1'b0 || m_ready !== 1'b1) begin
            n_err++;
            $display("FAIL late_rvalid: wv=%b req=%b rdy=%b want 0 0 1", w_valid, dmem_req, m_ready);
        end
    endtask

    task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
        for (int k = 0; k < 2; k++) begin
            m_valid = 1; m_mem_ren = (k == 0); m_mem_wen = (k == 1);
            m_mem_type = (k == 0) ? 3'b010 : 3'b001;
            m_alu_sum = (k == 0) ? 32'h102 : 32'h301;
            m_rd = 5'd6; m_reg_wen = (k == 0);
            step();
            m_valid = 0; m_mem_ren = 0; m_mem_wen = 0;
            n_vec++;
            if (dmem_req !== 1'b0 || w_valid !== 1'b1 || w_reg_wen !== 1'b0 || w_exc !== 1'b1 ||
                w_exc_cause !== ((k == 0) ? 4'd4 : 4'd6) ||
                w_badaddr !== ((k == 0) ? 32'h102 : 32'h301)) begin
                n_err++;
                $display("FAIL misalign_trap[%0d]: req=%b wv=%b wen=%b exc=%b cause=%0d bad=%h",
                         k, dmem_req, w_valid, w_reg_wen, w_exc, w_exc_cause, w_badaddr);
            end
        end
        step();
`else
        do_mem(0, 3'b010, 32'h102, 32'h0, 32'h1122_3344, 0, 1, 5'd6);
        do_mem(0, 3'b001, 32'h103, 32'h0, 32'h8001_7FFF, 1, 1, 5'd8);
        do_mem(1, 3'b001, 32'h101, 32'h0000_BEEF, 32'h0, 0, 1, 5'd0);
`endif
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_stall();
        test_spec_mem();
        test_random_mem();
        test_misalign();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
